// File: rtl/dbus_initiator.sv
// Data-bus initiator: takes one load/store at a time from the pipeline and runs it against the
// negedge-sampled data memory or the memory-mapped I/O region, returning a response with an error flag.
module dbus_initiator #(
  parameter int unsigned                ADDR_BIT_WIDTH = 32,
  parameter int unsigned                DATA_BIT_WIDTH = 32,
  parameter logic [ADDR_BIT_WIDTH-1:0]  MEM_LIMIT      = 32'h0000_0800,
  parameter int unsigned                IO_BIT         = 29,
  parameter int unsigned                IO_TIMEOUT     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_BIT_WIDTH-1:0] req_addr,
  input  logic [DATA_BIT_WIDTH-1:0] req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_BIT_WIDTH-1:0] resp_rdata,
  output logic                      resp_err,
  output logic                      mem_wren,
  output logic [ADDR_BIT_WIDTH-1:0] mem_addr,
  output logic [DATA_BIT_WIDTH-1:0] mem_din,
  input  logic [DATA_BIT_WIDTH-1:0] mem_dout,
  output logic                      io_sel,
  output logic                      io_we,
  input  logic                      io_ack,
  input  logic [DATA_BIT_WIDTH-1:0] io_rdata,
  output logic [1:0]                dbg_state
);

  // Handshakes: a request transfers on a posedge where req_valid && req_ready; a response
  // transfers on a posedge where resp_valid && resp_ready. Sources hold their payload until then.

  localparam int unsigned CW = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(IO_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE_MEM = 2'd1,
    WAIT_IO   = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic                      we_q, we_d;
  logic [ADDR_BIT_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_BIT_WIDTH-1:0] din_q, din_d;
  logic [DATA_BIT_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic addr_bad;

  // Misaligned, or in the memory region but past its end (unsigned full-width compare).
  assign addr_bad = (req_addr[1:0] != 2'b00) ||
                    (!req_addr[IO_BIT] && (req_addr >= MEM_LIMIT));

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d   = req_we;
          addr_d = req_addr;
          din_d  = req_wdata;
          cnt_d  = '0;
          if (addr_bad) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (req_addr[IO_BIT]) begin
            state_d = WAIT_IO;
          end else begin
            state_d = ISSUE_MEM;
          end
        end
      end
      ISSUE_MEM: begin
        rdata_d = we_q ? '0 : mem_dout;
        err_d   = 1'b0;
        state_d = RESP;
      end
      WAIT_IO: begin
        // An ack in the final cycle still counts as success.
        if (io_ack) begin
          rdata_d = we_q ? '0 : io_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_wren   = (state_q == ISSUE_MEM) && we_q;
  assign mem_addr   = addr_q;
  assign mem_din    = din_q;
  assign io_sel     = (state_q == WAIT_IO);
  assign io_we      = (state_q == WAIT_IO) && we_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dbus_initiator.sv
// Bench for dbus_initiator: negedge-sampled memory model, scripted I/O responder,
// and a word-array reference model predicting every response, latency and strobe count.
module tb_dbus_initiator;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, resp_ready, io_ack;
  logic [31:0] req_addr, req_wdata, io_rdata;
  logic        req_ready, resp_valid, resp_err, mem_wren, io_sel, io_we;
  logic [31:0] resp_rdata, mem_addr, mem_din;
  logic [31:0] mem_dout;
  logic [1:0]  dbg_state;

  logic [31:0] mem_arr [0:511];
  logic [31:0] ref_mem [0:511];
  logic [32:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  dbus_initiator dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .io_sel(io_sel), .io_we(io_we), .io_ack(io_ack), .io_rdata(io_rdata),
    .dbg_state(dbg_state)
  );

  // clock / memory model
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wren) mem_arr[mem_addr[10:2]] <= mem_din;
    mem_dout <= mem_arr[mem_addr[10:2]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  req_ready,  1);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_err"},   resp_err,   0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_wren"},       mem_wren,   0);
    chk({tag, "_mem_addr"},   mem_addr,   0);
    chk({tag, "_mem_din"},    mem_din,    0);
    chk({tag, "_io_sel"},     io_sel,     0);
    chk({tag, "_io_we"},      io_we,      0);
  endtask

  // ack_dly: io_ack asserted in the ack_dly-th io_sel cycle; 0 means never.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_dly, input logic [31:0] io_val, input int hold);
    logic        e_err;
    logic [31:0] e_rd, held;
    int e_lat, e_ioc, e_wc, lat, ioc, wc, bad_we;
    // reference model
    if (addr[1:0] != 2'b00 || (!addr[29] && addr >= 32'h800)) begin
      e_err = 1; e_rd = 0; e_lat = 1; e_ioc = 0; e_wc = 0;
    end else if (addr[29]) begin
      e_wc = 0;
      if (ack_dly >= 1 && ack_dly <= T) begin
        e_err = 0; e_rd = we ? 32'h0 : io_val; e_lat = ack_dly + 1; e_ioc = ack_dly;
      end else begin
        e_err = 1; e_rd = 0; e_lat = T + 1; e_ioc = T;
      end
    end else begin
      e_err = 0; e_lat = 2; e_ioc = 0; e_wc = we ? 1 : 0;
      e_rd = we ? 32'h0 : ref_mem[addr[10:2]];
      if (we) ref_mem[addr[10:2]] = wdata;
    end

    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata;
    io_ack = 0; io_rdata = io_val;
    chk("req_ready_idle", req_ready, 1);
    exp_q.push_back({e_err, e_rd});
    @(negedge clk);
    req_valid = 0;
    lat = 1; ioc = 0; wc = 0; bad_we = 0;
    while (!resp_valid && lat < 40) begin
      if (mem_wren) wc++;
      if (io_sel) begin
        ioc++;
        if (io_we !== we) bad_we++;
        io_ack = (ioc == ack_dly);
      end else begin
        io_ack = 0;
      end
      @(negedge clk);
      lat++;
    end
    io_ack = 0;
    if (!resp_valid) begin
      chk("resp_wait_bound", 0, 1);
      void'(exp_q.pop_front());
      return;
    end
    chk("latency", lat, e_lat);
    chk("io_sel_cycles", ioc, e_ioc);
    chk("wren_cycles", wc, e_wc);
    chk("io_we", bad_we, 0);
    chk("mem_addr_latched", mem_addr, addr);
    chk("mem_din_latched", mem_din, wdata);
    chk("req_ready_busy", req_ready, 0);
    chk("resp", {resp_err, resp_rdata}, exp_q.pop_front());
    held = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1; req_we = 1; req_addr = 32'h40; req_wdata = 32'hBAD0BAD0;
      @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, held);
      chk("hold_ready", req_ready, 0);
      chk("hold_wren", mem_wren, 0);
    end
    req_valid = 0;
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    chk("resp_drop", resp_valid, 0);
    chk("back_idle", req_ready, 1);
  endtask

  // Reset asserted during the ISSUE_MEM cycle of a store (io=0) or the first WAIT_IO cycle (io=1).
  task automatic do_reset_mid(input logic io, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = addr; req_wdata = wdata; io_ack = 0;
    @(negedge clk);
    req_valid = 0;
    chk(io ? "mid_io_sel" : "mid_wren", io ? io_sel : mem_wren, 1);
    reset = 1;
    @(negedge clk);
    chk_reset_outputs(io ? "rst_io" : "rst_mem");
    reset = 0;
    if (!io) begin
      ref_mem[addr[10:2]] = wdata;
      chk("store_committed", mem_arr[addr[10:2]], wdata);
    end
    @(negedge clk);
    chk("no_resp_after_rst", resp_valid, 0);
  endtask

  initial begin
    logic [31:0] a, d;
    int kind;
    reset = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    resp_ready = 0; io_ack = 0; io_rdata = 0;
    for (int i = 0; i < 512; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 0;

    // directed cases
    do_txn(1, 32'h10, 32'hDEADBEEF, 0, 0, 0);
    do_txn(0, 32'h10, 32'h0, 0, 0, 0);
    do_txn(0, 32'h7FC, 32'h0, 0, 0, 0);
    do_txn(0, 32'h800, 32'h0, 0, 0, 0);
    do_txn(1, 32'h12, 32'h12345678, 0, 0, 0);
    do_txn(0, 32'h10, 32'h0, 0, 0, 0);
    do_txn(0, 32'h2000_0004, 32'h0, 3, 32'h55, 0);
    do_txn(0, 32'h2000_0004, 32'h0, 0, 32'h55, 0);
    do_txn(1, 32'h2000_0008, 32'hCAFE, T, 32'h77, 0);
    do_txn(1, 32'hFFFF_FFFC & ~32'h2000_0000, 32'h1, 0, 0, 0);
    do_txn(0, 32'h20, 32'h0, 0, 0, 5);
    do_reset_mid(0, 32'h44, 32'hA5A5_0F0F);
    do_txn(0, 32'h44, 32'h0, 0, 0, 0);
    do_reset_mid(1, 32'h2000_0010, 32'h0);
    do_txn(0, 32'h2000_0010, 32'h0, 1, 32'h9, 0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 5);
      d = $urandom;
      case (kind)
        0, 1:    a = {21'd0, 9'($urandom_range(0, 511)), 2'b00};
        2:       a = {21'd0, 9'($urandom_range(0, 511)), 2'($urandom_range(1, 3))};
        3:       a = ($urandom | 32'h800) & 32'hDFFF_FFFC;
        default: a = ($urandom | 32'h2000_0000) & 32'hFFFF_FFFC;
      endcase
      do_txn(1'($urandom_range(0, 1)), a, d, $urandom_range(0, T + 2), $urandom,
             $urandom_range(0, 2));
    end

    chk("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
